uart_rx: RTL and testbench

- UART receive engine: the receive-side counterpart to the transmit path.
- Consumes the 16x oversampling tick from the team's baud rate generator and de-serialises asynchronous frames: 1 start bit, DATA_BITS data bits sent LSB first, optional parity, 1 stop bit.
- Delivers each byte through a single-entry holding register with a valid/ready handshake, and reports parity, framing and overrun errors.
- Sits between the pin-side serial input and the bus-side RX consumer.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive engine: 16x-oversampled start/data/parity/stop de-serialiser
// with a single-entry holding register, valid/ready handoff and error flags.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLING);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLING / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;

  logic sample_mid;
  logic sample_end;
  logic fall_edge;
  logic can_load;

  assign sample_mid = tick_16x && (tick_cnt == TICK_MID);
  assign sample_end = tick_16x && (tick_cnt == TICK_LAST);
  assign fall_edge  = rx_s_d && !rx_s;
  assign can_load   = !rx_valid || rx_ready;

  // Two-flop synchroniser plus one history flop for start-edge detection.
  // Reset to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a real shift chain.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      // NOTE: the datapath registers are reset as well so a mid-frame reset
      // can never leave stale bits that later reach rx_data.
      shreg       <= '0;
      par_err_q   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;

      // Consumer handshake; a commit in the STOP branch below takes priority.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state != IDLE && tick_16x) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      case (state)
        IDLE: begin
          // Edge-triggered so a held-low line (break) cannot retrigger.
          if (fall_edge) begin
            tick_cnt <= '0;
            state    <= START;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (sample_mid) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
              state     <= DATA;
            end
          end
        end

        DATA: begin
          if (sample_end) begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state <= PAR_ON ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (sample_end) begin
            par_err_q <= (^shreg) ^ rx_s ^ PAR_ODD;
            tick_cnt  <= '0;
            state     <= STOP;
          end
        end

        STOP: begin
          // Commit at mid stop bit and go idle at once, leaving half a bit
          // to catch a back-to-back start edge.
          if (sample_end) begin
            tick_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            if (can_load) begin
              rx_data    <= shreg;
              parity_err <= PAR_ON && par_err_q;
              frame_err  <= ~rx_s;
              rx_valid   <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance without parity, one with even
// parity; table vectors, hand-written corner sequences and random frames.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_16x = 1'b0;
  logic [1:0] tick_div = 2'd0;

  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx_ready0 = 1'b0;
  logic       rx_ready1 = 1'b0;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       parity_err0, parity_err1;
  logic       frame_err0, frame_err1;
  logic       overrun0, overrun1;
  logic       busy0, busy1;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt0 = 0;
  logic [7:0] got_q[$];

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLING(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .parity_err(parity_err0), .frame_err(frame_err0),
    .overrun_err(overrun0), .busy(busy0)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLING(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx(rx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .parity_err(parity_err1), .frame_err(frame_err1),
    .overrun_err(overrun1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // One tick every 4 clks: 16 ticks = 64 clks per bit.
  always @(negedge clk) begin
    tick_div = tick_div + 2'd1;
    tick_16x = (tick_div == 2'd0);
  end

  always @(negedge clk) begin
    if (overrun0) ovr_cnt0++;
    if (rx_valid0 && rx_ready0) got_q.push_back(rx_data0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic b);
    if (sel == 0) rx0 = b;
    else          rx1 = b;
  endtask

  task automatic set_ready(input int sel, input logic b);
    if (sel == 0) rx_ready0 = b;
    else          rx_ready1 = b;
  endtask

  task automatic get_out(input int sel, output logic v, output logic [7:0] d,
                         output logic pe, output logic fe, output logic b);
    if (sel == 0) begin
      v = rx_valid0; d = rx_data0; pe = parity_err0; fe = frame_err0; b = busy0;
    end else begin
      v = rx_valid1; d = rx_data1; pe = parity_err1; fe = frame_err1; b = busy1;
    end
  endtask

  // Start bit, 8 data bits LSB first, parity bit on the parity instance, stop bit.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic par,
                            input logic stop, input logic release_line);
    set_rx(sel, 1'b0);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, data[i]);
      wait_clks(BIT_CLKS);
    end
    if (sel == 1) begin
      set_rx(sel, par);
      wait_clks(BIT_CLKS);
    end
    set_rx(sel, stop);
    wait_clks(BIT_CLKS);
    if (release_line) set_rx(sel, 1'b1);
  endtask

  task automatic wait_valid(input int sel, input int budget);
    logic v, pe, fe, b;
    logic [7:0] d;
    int n = 0;
    get_out(sel, v, d, pe, fe, b);
    while (!v && n < budget) begin
      @(negedge clk);
      n++;
      get_out(sel, v, d, pe, fe, b);
    end
    check("valid_arrives", {31'd0, v}, 32'd1);
  endtask

  task automatic accept(input int sel, input string name);
    logic v, pe, fe, b;
    logic [7:0] d;
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
    get_out(sel, v, d, pe, fe, b);
    check(name, {31'd0, v}, 32'd0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  initial begin
    vec_t vecs[8];
    exp_t exp_q[$];
    exp_t e;
    logic v, pe, fe, b;
    logic [7:0] d;
    logic bad;
    int n;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    // Reset state
    wait_clks(4);
    for (int s = 0; s < 2; s++) begin
      get_out(s, v, d, pe, fe, b);
      check("reset_valid", {31'd0, v}, 32'd0);
      check("reset_data", {24'd0, d}, 32'd0);
      check("reset_perr", {31'd0, pe}, 32'd0);
      check("reset_ferr", {31'd0, fe}, 32'd0);
      check("reset_busy", {31'd0, b}, 32'd0);
    end
    check("reset_overrun", {31'd0, overrun0}, 32'd0);
    rst_n = 1'b1;
    wait_clks(8);

    // Table-driven frames: deliver, hold until accepted, drop one clk later
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop, 1'b1);
      wait_valid(vecs[i].sel, 200);
      get_out(vecs[i].sel, v, d, pe, fe, b);
      check("tbl_data", {24'd0, d}, {24'd0, vecs[i].exp_data});
      check("tbl_perr", {31'd0, pe}, {31'd0, vecs[i].exp_perr});
      check("tbl_ferr", {31'd0, fe}, {31'd0, vecs[i].exp_ferr});
      wait_clks(2 * BIT_CLKS);
      get_out(vecs[i].sel, v, d, pe, fe, b);
      check("tbl_hold_valid", {31'd0, v}, 32'd1);
      accept(vecs[i].sel, "tbl_accept_drop");
      get_out(vecs[i].sel, v, d, pe, fe, b);
      check("tbl_data_after_accept", {24'd0, d}, {24'd0, vecs[i].exp_data});
      wait_clks(8);
    end

    // Framing error followed by a 20-bit break: no retrigger while held low
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    wait_valid(0, 200);
    check("brk_data", {24'd0, rx_data0}, 32'h55);
    check("brk_ferr", {31'd0, frame_err0}, 32'd1);
    accept(0, "brk_accept");
    bad = 1'b0;
    for (int i = 0; i < 20 * BIT_CLKS; i++) begin
      @(negedge clk);
      if (rx_valid0 || busy0) bad = 1'b1;
    end
    check("brk_no_retrigger", {31'd0, bad}, 32'd0);
    rx0 = 1'b1;
    wait_clks(BIT_CLKS);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 200);
    check("brk_next_data", {24'd0, rx_data0}, 32'h5A);
    check("brk_next_ferr", {31'd0, frame_err0}, 32'd0);
    accept(0, "brk_next_accept");

    // Glitch shorter than half a bit: false start
    wait_clks(16);
    rx0 = 1'b0;
    wait_clks(4);
    rx0 = 1'b1;
    check("glitch_busy_rises", {31'd0, busy0}, 32'd1);
    n = 0;
    while (busy0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_drops", {31'd0, busy0}, 32'd0);
    wait_clks(BIT_CLKS);
    check("glitch_no_valid", {31'd0, rx_valid0}, 32'd0);

    // Back-to-back frames with rx_ready low: overrun, first word kept
    ovr_cnt0 = 0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    wait_clks(4);
    check("ovr_valid", {31'd0, rx_valid0}, 32'd1);
    check("ovr_data_kept", {24'd0, rx_data0}, 32'h11);
    check("ovr_pulse_count", ovr_cnt0, 32'd1);
    accept(0, "ovr_accept");

    // Same pair with rx_ready high: both delivered, no overrun
    rx_ready0 = 1'b1;
    wait_clks(2);
    got_q.delete();
    ovr_cnt0 = 0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    wait_clks(4);
    rx_ready0 = 1'b0;
    check("b2b_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b_first", {24'd0, got_q[0]}, 32'h11);
      check("b2b_second", {24'd0, got_q[1]}, 32'h22);
    end
    check("b2b_no_overrun", ovr_cnt0, 32'd0);

    // Reset during bit 3 of a frame, with a prior word still held
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 200);
    rx0 = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx0 = 1'b0;
      wait_clks(BIT_CLKS);
    end
    rx0 = 1'b1;
    wait_clks(BIT_CLKS / 2);
    check("mid_busy_before_rst", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, rx_valid0}, 32'd0);
    check("rst_data", {24'd0, rx_data0}, 32'd0);
    check("rst_ferr", {31'd0, frame_err0}, 32'd0);
    check("rst_perr", {31'd0, parity_err0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(8);
    check("rst_no_partial", {31'd0, rx_valid0}, 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 200);
    check("post_rst_data", {24'd0, rx_data0}, 32'h3C);
    check("post_rst_ferr", {31'd0, frame_err0}, 32'd0);
    accept(0, "post_rst_accept");

    // Random frames against the reference model
    for (int i = 0; i < 24; i++) begin
      int         sel;
      logic [7:0] data;
      logic       par, stop;
      sel  = int'($urandom_range(0, 1));
      data = 8'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      e.data = data;
      e.perr = (sel == 1) ? ((^data) ^ par) : 1'b0;
      e.ferr = !stop;
      exp_q.push_back(e);
      send_frame(sel, data, par, stop, 1'b1);
      wait_valid(sel, 200);
      e = exp_q.pop_front();
      get_out(sel, v, d, pe, fe, b);
      check("rnd_data", {24'd0, d}, {24'd0, e.data});
      check("rnd_perr", {31'd0, pe}, {31'd0, e.perr});
      check("rnd_ferr", {31'd0, fe}, {31'd0, e.ferr});
      accept(sel, "rnd_accept");
      if (!stop) wait_clks(BIT_CLKS);
      else       wait_clks(int'($urandom_range(0, 64)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
